// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - constant-latency restoring divider with start/done handshake
// One quotient bit per cycle, always WIDTH iterations, zero divisor handled by the same datapath.
module sequential_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             quotientDone
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] dreg;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] next_r;

    // Extra bit keeps the shifted-in dividend bit; MSB of trial is the borrow.
    assign trial = {r, q[WIDTH-1]} - {1'b0, dreg};

    always_comb begin
        next_q = {q[WIDTH-2:0], 1'b0};
        next_r = {r[WIDTH-2:0], q[WIDTH-1]};
        if (!trial[WIDTH]) begin
            next_q = {q[WIDTH-2:0], 1'b1};
            next_r = trial[WIDTH-1:0];
        end
    end

    assign busy         = (state == RUN);
    assign quotientDone = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= '0;
            r         <= '0;
            dreg      <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dreg  <= divisor;
                        q     <= dividend;
                        r     <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    q   <= next_q;
                    r   <= next_r;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        quotient  <= next_q;
                        remainder <= next_r;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sequential_divider.md
# sequential_divider

Constant-time sequential restoring divider for unsigned operands, the inverse companion to the shift-add multiplier. It has the same start/done handshake style, so testers can instantiate it in pairs and check timing non-interference and functional properties such as divide-then-multiply round trips. Latency is fixed at WIDTH iterations regardless of operand values, including a zero divisor, so completion time carries no information about the data.

## Interface
- WIDTH, 32, operand and result width in bits (>= 2)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  WIDTH  unsigned numerator; captured on accepted start
- divisor  input  WIDTH  unsigned denominator; captured on accepted start
- quotient  output  WIDTH  registered result; valid while quotientDone=1
- remainder  output  WIDTH  registered result; valid while quotientDone=1
- busy  output  1  high while iterating (RUN)
- quotientDone  output  1  level; high in DONE until next accepted start or rst

## Operation
- States: IDLE, RUN, DONE.
- In IDLE, start=1 is accepted:
  - Latch divisor into dreg.
  - Set q <= dividend, r <= 0, cnt <= 0.
  - Go to RUN.
- In IDLE, start=0: stay in IDLE.
- In RUN, each cycle performs one restoring iteration:
  - Form trial = {r, q[WIDTH-1]} - {1'b0, dreg}, computed at WIDTH+1 bits.
  - If trial is non-negative (MSB=0): r <= trial[WIDTH-1:0] and q <= {q[WIDTH-2:0], 1'b1}.
  - Otherwise: r <= {r[WIDTH-2:0], q[WIDTH-1]} and q <= {q[WIDTH-2:0], 1'b0}.
  - cnt <= cnt+1.
  - On the iteration where cnt == WIDTH-1:
    - Also load quotient <= next q and remainder <= next r.
    - Go to DONE.
- No early termination: exactly WIDTH RUN cycles, independent of operands.
- In RUN, start is ignored, and input changes have no effect (operands were latched at start).
- In DONE, quotientDone=1 and outputs hold.
  - start=1 is accepted exactly as in IDLE; quotientDone drops in the same edge.
  - start=0: stay in DONE.
- Divisor = 0 needs no special case. Every trial succeeds, giving quotient = all ones and remainder = dividend, in the same WIDTH cycles.
- Width rules:
  - The trial subtraction is WIDTH+1 bits so the shifted-in bit is never lost.
  - r never exceeds WIDTH bits, because r < dreg is invariant whenever dreg != 0.
- quotient and remainder change only at the RUN→DONE edge or on rst. They hold the previous result during RUN.

## Timing
- Reset values (the edge with rst=1):
  - State = IDLE.
  - quotient = 0, remainder = 0, busy = 0, quotientDone = 0.
  - cnt = 0, q = 0, r = 0, dreg = 0.
- rst takes priority over start and over any state. Reset mid-RUN aborts the operation, and the result is not written.
- Start accepted at edge N:
  - busy = 1 after edge N.
  - The final iteration occurs at edge N+WIDTH.
  - After edge N+WIDTH: busy = 0, quotientDone = 1, outputs valid.
- Latency from accepted start to quotientDone is exactly WIDTH cycles. Two instances started on the same edge raise quotientDone on the same edge for any operand values.
- Back-to-back: a start held high in DONE restarts immediately, so quotientDone is high for exactly one cycle between jobs.
- busy and quotientDone are never high simultaneously.

## Test plan
- WIDTH=32, dividend=100, divisor=7, start pulse at edge N → quotientDone rises after edge N+32, quotient=14, remainder=2, busy low.
- dividend=0xFFFFFFFF, divisor=1 → quotient=0xFFFFFFFF, remainder=0. Then dividend=5, divisor=0xFFFFFFFF → quotient=0, remainder=5; both after 32 cycles.
- Divide by zero: dividend=0x1234, divisor=0 → quotient=0xFFFFFFFF, remainder=0x1234, done at exactly cycle 32.
- Two instances started together, first with (0xDEADBEEF, 3) and second with (1, 0x80000000) → quotientDone identical every cycle. Second instance gives quotient=0, remainder=1.
- Start pulses and operand changes during RUN (cycles 5, 17) are ignored → result matches the original operands; done at cycle 32 after the first start.
- rst asserted at RUN cycle 10 → next cycle IDLE, all outputs 0. A new start (9/4) then gives quotient=2, remainder=1 after 32 cycles.
